// File: rtl/grf_mp.sv
// -----------------------------------------------------------------------------
// grf_mp -- parametrised multi-port general register file with busy scoreboard.
//
// Two write ports:
//   port 0 : main pipeline writeback
//   port 1 : long-latency unit (mult/div) writeback
//            port 1 takes priority when both ports write the same address.
// NRD combinational read ports, with optional same-cycle write-to-read bypass.
// A per-register busy bit works as a scoreboard for stall generation:
//   - set on issue
//   - cleared on writeback
//   - set wins if both happen to one register in the same cycle.
// Register 0 always reads as zero and is never busy.
//
// Parameters:
//   DATA_W  register width in bits
//   ADDR_W  address width (depth = 2**ADDR_W)
//   NRD     number of read ports (1..4)
//   BYPASS  1: reads see this cycle's write data; 0: stored contents only
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous, active-high; clears registers and busy bits
//   rd_addr   read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rd_data   read data,      port k at [k*DATA_W +: DATA_W]
//   rd_busy   busy bit of the register addressed by read port k
//   we0/wa0/wd0/wpc0  write port 0: enable, address, data, PC (trace only)
//   we1/wa1/wd1/wpc1  write port 1: enable, address, data, PC (trace only)
//   iss_en/iss_addr   issue: mark destination register busy
//   busy_any  OR of all busy bits
//
// Build option:
//   GRF_MP_TRACE_EN  when defined, every committed write prints one line:
//                    "<time>@<wpc hex>: $<addr dec> <= <data hex>"
//                    When undefined, wpc0/wpc1 are unused.
// -----------------------------------------------------------------------------
module grf_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2,
    parameter int BYPASS = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NRD*ADDR_W-1:0] rd_addr,
    output logic [NRD*DATA_W-1:0] rd_data,
    output logic [NRD-1:0]        rd_busy,
    input  logic                  we0,
    input  logic [ADDR_W-1:0]     wa0,
    input  logic [DATA_W-1:0]     wd0,
    input  logic [31:0]           wpc0,
    input  logic                  we1,
    input  logic [ADDR_W-1:0]     wa1,
    input  logic [DATA_W-1:0]     wd1,
    input  logic [31:0]           wpc1,
    input  logic                  iss_en,
    input  logic [ADDR_W-1:0]     iss_addr,
    output logic                  busy_any
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;

    // Qualified write strobes: writes to register 0 are dropped.
    logic wr0, wr1;
    assign wr0 = we0 && (wa0 != '0);
    assign wr1 = we1 && (wa1 != '0);

    // Next-state for storage and scoreboard.
    // NOTE: every variable assigned in always_comb receives a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;

        // Port 1 is applied after port 0, so it wins a collision.
        if (wr0) begin
            regs_d[wa0] = wd0;
            busy_d[wa0] = 1'b0;
        end
        if (wr1) begin
            regs_d[wa1] = wd1;
            busy_d[wa1] = 1'b0;
        end

        // Issue is applied after the clears: the newly issued producer is
        // younger than any instruction writing back this cycle.
        if (iss_en) begin
            busy_d[iss_addr] = 1'b1;
        end

        regs_d[0] = '0;
        busy_d[0] = 1'b0;
    end

    // NOTE: this storage array is deliberately given an asynchronous reset
    // (the register file must read all-zero immediately on reset). A file that
    // needs no reset value should leave its memory out of the reset branch so
    // it can map onto RAM. Sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs_q <= '{default: '0};
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    // Combinational read ports.
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] val;

        assign ra = rd_addr[k*ADDR_W +: ADDR_W];

        always_comb begin
            val = regs_q[ra];
            if (BYPASS != 0) begin
                // Same priority as the commit, so the bypassed value equals
                // what is stored after the edge.
                if (wr0 && (wa0 == ra)) val = wd0;
                if (wr1 && (wa1 == ra)) val = wd1;
            end
            // Reset gating also masks bypassed write data while reset is high.
            if ((ra == '0) || reset) val = '0;
        end

        assign rd_data[k*DATA_W +: DATA_W] = val;
        // The busy bit is never bypassed: it reflects the stored scoreboard.
        assign rd_busy[k] = busy_q[ra];
    end

    assign busy_any = |busy_q;

`ifdef GRF_MP_TRACE_EN
    // Port 0 prints first. On a collision only the port 1 line appears,
    // because only port 1's data is committed.
    always @(posedge clk) begin
        if (!reset) begin
            if (wr0 && !(wr1 && (wa1 == wa0)))
                $display("%0t@%h: $%0d <= %h", $time, wpc0, wa0, wd0);
            if (wr1)
                $display("%0t@%h: $%0d <= %h", $time, wpc1, wa1, wd1);
        end
    end
`else
    logic unused_wpc;
    assign unused_wpc = ^{wpc0, wpc1};
`endif

endmodule

// File: doc/grf_mp.md
Name: grf_mp

Overview:
- Parametrised multi-port general register file; successor to the single-write, dual-read GRF in the CPU datapath.
- Sits between the decode stage (reads, destination issue) and writeback. It has two write ports: port 0 is the main pipeline writeback, port 1 is the long-latency unit (mult/div) writeback.
- Adds configurable width, depth and read-port count, optional write-to-read bypass, and a per-register busy scoreboard for stall generation.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2^ADDR_W
- NRD, 2, number of read ports (1..4)
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = read returns stored value only

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high; clears all registers and busy bits
- rd_addr  in  NRD*ADDR_W  read addresses; port k at [k*ADDR_W +: ADDR_W]
- rd_data  out  NRD*DATA_W  read data; port k at [k*DATA_W +: DATA_W]
- rd_busy  out  NRD  scoreboard busy bit of the register addressed by port k
- we0  in  1  write enable, port 0
- wa0  in  ADDR_W  write address, port 0
- wd0  in  DATA_W  write data, port 0
- wpc0  in  32  PC of the instruction writing via port 0 (trace only)
- we1  in  1  write enable, port 1
- wa1  in  ADDR_W  write address, port 1
- wd1  in  DATA_W  write data, port 1
- wpc1  in  32  PC for port 1 (trace only)
- iss_en  in  1  issue: mark destination busy
- iss_addr  in  ADDR_W  destination register being issued
- busy_any  out  1  OR of all busy bits

Behaviour:
- Storage: 2^ADDR_W x DATA_W registers.
- Register 0 is hardwired to zero. Writes to address 0 are dropped, reads of address 0 return 0, and its busy bit is never set.
- Reset (asynchronous, active-high) forces all registers to 0 and all busy bits to 0. While reset is asserted: rd_data = 0 for every address, rd_busy = 0, busy_any = 0.
- Writes commit on the rising clk edge when we_n = 1 and wa_n != 0.
- Write collision: if we0 and we1 target the same nonzero address in one cycle, port 1 data is stored.
- Reads are combinational.
- BYPASS=1: if a write port is writing a nonzero rd_addr this cycle, rd_data shows that write data. On a collision, port 1 data is shown, so the read value matches what is stored after the edge.
- BYPASS=0: reads show stored contents only. Write data becomes visible the cycle after the edge.
- Scoreboard, per register, one bit, updated on the clk edge:
  - set when iss_en = 1 and iss_addr matches (nonzero address only);
  - cleared when either write port writes that address;
  - set and clear in the same cycle on the same register: set wins, because the new producer is younger.
- rd_busy[k] is the current busy bit of rd_addr[k]; it is combinational and not bypassed.
- busy_any is combinational.
- Issuing an already-busy register leaves it busy. No counting: a single write clears it.
- Latency: write to visible read is 0 cycles (BYPASS=1) or 1 cycle (BYPASS=0). Issue to rd_busy is 1 cycle.
- Reset asserted mid-operation: state clears immediately, regardless of clk. Writes or issues pending in that cycle are lost.

Optional Feature:
- Macro: GRF_MP_TRACE_EN.
- Defined: on every committed write the block prints "<time>@<wpc hex>: $<addr dec> <= <data hex>", one line per port. Port 0 prints before port 1. Nothing is printed for writes to register 0.
- On a collision, only the port 1 line is printed.
- Not defined: no $display code is compiled, and the wpc0/wpc1 ports remain but are unused.
- Register and scoreboard behaviour is identical in both cases.

Test Plan:
- Reset: assert reset mid-cycle after writing $5=0x1234 -> rd_data for $5 reads 0 immediately, before any clk edge; busy_any=0.
- Zero register: we0=1, wa0=0, wd0=0xFFFFFFFF -> reading $0 returns 0 both during and after the edge.
- Bypass with NRD=2, BYPASS=1: we0 writes $8=0xDEADBEEF while rd_addr port 1 = 8 -> rd_data port 1 = 0xDEADBEEF in the same cycle. With BYPASS=0 it reads the old value, then 0xDEADBEEF next cycle.
- Collision: we0 $3=0x11 and we1 $3=0x22 in one cycle -> $3 reads 0x22 (bypass and stored); trace build prints only the 0x22 line.
- Scoreboard: iss $9 -> next cycle rd_busy=1 and busy_any=1. Then we1 writes $9=0x7 -> next cycle rd_busy=0. In a separate cycle, iss $9 together with we0 to $9 -> $9 stays busy.
- Parameter sweep: DATA_W=16, ADDR_W=3, NRD=4 -> write 0xA5A5 to $7, all four ports read 0xA5A5 at address 7; address 0 reads 0.
